// File: rtl/sram_rr_if.sv
// Request/response/SRAM bundle around sram_rr_arbiter. The master modport is the
// environment side: both requesters plus the SRAM control FSM and array.
interface sram_rr_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_rnw;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              req1_valid;
  logic              req1_rnw;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp0_valid;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              sram_enable;
  logic              sram_rnw;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata;
  logic              sram_ready;
  logic              busy;
  logic              sync_err;

  modport master (
    output req0_valid, req0_rnw, req0_addr, req0_wdata,
    output req1_valid, req1_rnw, req1_addr, req1_wdata,
    output sram_rdata, sram_ready,
    input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    input  sram_enable, sram_rnw, sram_addr, sram_wdata, busy, sync_err
  );

  modport slave (
    input  req0_valid, req0_rnw, req0_addr, req0_wdata,
    input  req1_valid, req1_rnw, req1_addr, req1_wdata,
    input  sram_rdata, sram_ready,
    output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_rdata,
    output sram_enable, sram_rnw, sram_addr, sram_wdata, busy, sync_err
  );
endinterface

// File: rtl/sram_rr_arbiter.sv
// Two-master round-robin front end for the 3-cycle SRAM control FSM, tracking it with a mirror FSM.
// Optional: define SRAM_SYNC_CHECK_EN to compare sram_ready against the mirror and recover on desync.
module sram_rr_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input logic      clk,
  input logic      rst_n,
  sram_rr_if.slave bus
);
  typedef enum logic [1:0] {A_IDLE, A_PRE, A_DEV, A_SNS} state_t;

  state_t            state;
  logic              last_grant;
  logic              op_id;
  logic              grant;
  logic              open_win;
  logic              launch;
  logic              sync_bad;
  logic              blocked;
  logic              rsp0_q;
  logic              rsp1_q;
  logic              rnw_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;

  assign open_win = (state == A_IDLE) || (state == A_SNS);

  always_comb begin
    // NOTE: assign a default before any condition so no path leaves grant unassigned (no latch).
    grant = bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) grant = ~last_grant;
  end

`ifdef SRAM_SYNC_CHECK_EN
  logic [1:0] hold_cnt;
  logic       sync_err_q;

  // The real FSM reports ready exactly in IDLE and SENSE; anything else means we lost track of it.
  assign sync_bad = (open_win != bus.sram_ready);
  assign blocked  = sync_bad || (hold_cnt != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt   <= 2'd0;
      sync_err_q <= 1'b0;
    end else if (sync_bad) begin
      hold_cnt   <= 2'd3;
      sync_err_q <= 1'b1;
    end else if (hold_cnt != 2'd0) begin
      hold_cnt <= hold_cnt - 2'd1;
    end
  end

  assign bus.sync_err = sync_err_q;
`else
  logic unused_sram_ready;

  assign unused_sram_ready = bus.sram_ready;
  assign sync_bad          = 1'b0;
  assign blocked           = 1'b0;
  assign bus.sync_err      = 1'b0;
`endif

  // rst_n gates launch so the FSM never sees enable while both sides are held in reset.
  assign launch = rst_n && open_win && (bus.req0_valid || bus.req1_valid) && !blocked;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= A_IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      rnw_q      <= 1'b1;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp0_q     <= 1'b0;
      rsp1_q     <= 1'b0;
      rdata_q    <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every reader sees pre-edge values.
      rsp0_q <= 1'b0;
      rsp1_q <= 1'b0;
      if (state == A_SNS && !sync_bad) begin
        rsp0_q <= ~op_id;
        rsp1_q <= op_id;
        if (rnw_q) rdata_q <= bus.sram_rdata;
      end

      unique case (state)
        A_IDLE:  state <= launch ? A_PRE : A_IDLE;
        A_PRE:   state <= A_DEV;
        A_DEV:   state <= A_SNS;
        A_SNS:   state <= launch ? A_PRE : A_IDLE;
        default: state <= A_IDLE;
      endcase
      if (sync_bad) state <= A_IDLE;

      if (launch) begin
        op_id      <= grant;
        last_grant <= grant;
        rnw_q      <= grant ? bus.req1_rnw   : bus.req0_rnw;
        addr_q     <= grant ? bus.req1_addr  : bus.req0_addr;
        wdata_q    <= grant ? bus.req1_wdata : bus.req0_wdata;
      end
    end
  end

  assign bus.req0_ready  = launch && !grant;
  assign bus.req1_ready  = launch && grant;
  assign bus.sram_enable = launch;
  assign bus.sram_rnw    = rnw_q;
  assign bus.sram_addr   = addr_q;
  assign bus.sram_wdata  = wdata_q;
  assign bus.rsp0_valid  = rsp0_q;
  assign bus.rsp1_valid  = rsp1_q;
  assign bus.rsp_rdata   = rdata_q;
  assign bus.busy        = (state != A_IDLE);
endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Directed bench for sram_rr_arbiter: SRAM FSM/array model, queue scoreboard and a response monitor.
// Define SRAM_SYNC_CHECK_EN for both RTL and bench to also exercise desync recovery.
module tb_sram_rr_arbiter;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_nrdy = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_rr_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_rr_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  // Environment: SRAM control FSM and a 16-word array that fills with 0x20+addr on reset, 0xA3 at 5.
  typedef enum logic [1:0] {E_IDLE, E_PRE, E_DEV, E_SNS} env_t;
  env_t       env_st;
  logic [7:0] mem [16];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      env_st <= E_IDLE;
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h20 + i);
      mem[5] <= 8'hA3;
    end else begin
      case (env_st)
        E_IDLE:  env_st <= bus.sram_enable ? E_PRE : E_IDLE;
        E_PRE:   env_st <= E_DEV;
        E_DEV:   env_st <= E_SNS;
        default: env_st <= bus.sram_enable ? E_PRE : E_IDLE;
      endcase
      if (env_st == E_SNS && !bus.sram_rnw) mem[bus.sram_addr] <= bus.sram_wdata;
    end
  end

  assign bus.sram_rdata = (env_st == E_SNS && bus.sram_rnw) ? mem[bus.sram_addr] : 8'hEE;
  assign bus.sram_ready = (env_st == E_IDLE || env_st == E_SNS) && !force_nrdy;

  typedef struct { bit id; logic [7:0] rdata; int due; } exp_t;
  typedef struct { bit id; int cyc; } acc_t;
  exp_t sb[$];
  acc_t acc_log[$];
  exp_t e;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.rsp0_valid || bus.rsp1_valid)) begin
      if (sb.size() == 0) begin
        check("rsp_unexpected", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("rsp_onehot", 32'(bus.rsp0_valid && bus.rsp1_valid), 32'd0);
        check("rsp_id", 32'(bus.rsp1_valid), 32'(e.id));
        check("rsp_cycle", 32'(cyc), 32'(e.due));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due) begin
      e = sb.pop_front();
      check("rsp_missing", 32'd0, 32'd1);
    end
  end

  task automatic drive(bit id, bit v, bit rnw, logic [3:0] a, logic [7:0] d);
    if (!id) begin
      bus.req0_valid = v; bus.req0_rnw = rnw; bus.req0_addr = a; bus.req0_wdata = d;
    end else begin
      bus.req1_valid = v; bus.req1_rnw = rnw; bus.req1_addr = a; bus.req1_wdata = d;
    end
  endtask

  task automatic wait_accept(bit id, output int acc);
    acc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (id ? bus.req1_ready : bus.req0_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) check("ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic accepted(bit id, int acc, bit push, logic [7:0] exp_rd);
    acc_log.push_back('{id, acc});
    if (push) sb.push_back('{id, exp_rd, acc + 4});
  endtask

  task automatic issue(bit id, bit rnw, logic [3:0] a, logic [7:0] d, logic [7:0] exp_rd, bit push,
                       output int acc);
    @(posedge clk); #1;
    drive(id, 1'b1, rnw, a, d);
    wait_accept(id, acc);
    if (acc >= 0) accepted(id, acc, push, exp_rd);
    @(posedge clk); #1;
    drive(id, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  // Valid held across ops: M0 reads 1..4, M1 writes 8..11; a write reports the preceding M0 read.
  task automatic stream(bit id);
    int acc;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      if (!id) drive(1'b0, 1'b1, 1'b1, 4'(i + 1), 8'h00);
      else     drive(1'b1, 1'b1, 1'b0, 4'(8 + i), 8'(8'h80 + i));
      wait_accept(id, acc);
      if (acc >= 0) accepted(id, acc, 1'b1, 8'(8'h21 + i));
      @(posedge clk); #1;
    end
    drive(id, 1'b0, 1'b0, 4'h0, 8'h00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);

    // Reset with a request pending: nothing may leak to the FSM.
    bus.req0_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_hold_enable", 32'(bus.sram_enable), 32'd0);
    check("rst_hold_ready0", 32'(bus.req0_ready), 32'd0);
    bus.req0_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_enable", 32'(bus.sram_enable), 32'd0);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_rsp", 32'({bus.rsp1_valid, bus.rsp0_valid}), 32'd0);
    check("idle_rdata", 32'(bus.rsp_rdata), 32'd0);
    check("idle_addr", 32'(bus.sram_addr), 32'd0);
    check("idle_wdata", 32'(bus.sram_wdata), 32'd0);
    check("idle_rnw", 32'(bus.sram_rnw), 32'd1);
    check("idle_sync_err", 32'(bus.sync_err), 32'd0);

    // M0 single read of 0x5: PRE/DEV/SNS busy, idle again at T+4 with response.
    issue(1'b0, 1'b1, 4'h5, 8'h00, 8'hA3, 1'b1, acc);
    @(negedge clk);
    check("rd_pre_addr", 32'(bus.sram_addr), 32'h5);
    check("rd_pre_rnw", 32'(bus.sram_rnw), 32'd1);
    check("rd_pre_busy", 32'(bus.busy), 32'd1);
    check("rd_pre_enable", 32'(bus.sram_enable), 32'd0);
    @(negedge clk);
    check("rd_dev_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("rd_sns_busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("rd_done_busy", 32'(bus.busy), 32'd0);

    // M1 write 0x3C to 0xF then read it back, launched back-to-back.
    issue(1'b1, 1'b0, 4'hF, 8'h3C, 8'hA3, 1'b1, acc);
    @(negedge clk);
    check("wr_rnw", 32'(bus.sram_rnw), 32'd0);
    check("wr_addr", 32'(bus.sram_addr), 32'hF);
    check("wr_wdata", 32'(bus.sram_wdata), 32'h3C);
    issue(1'b1, 1'b1, 4'hF, 8'h00, 8'h3C, 1'b1, acc);
    @(negedge clk);
    check("rdback_rnw", 32'(bus.sram_rnw), 32'd1);
    check("rdback_addr", 32'(bus.sram_addr), 32'hF);
    repeat (4) @(negedge clk);
    check("rdback_rdata", 32'(bus.rsp_rdata), 32'h3C);

    // Both masters held valid: strict alternation starting with M0, one launch every 3 cycles.
    acc_log.delete();
    fork
      stream(1'b0);
      stream(1'b1);
    join
    check("stream_ops", 32'(acc_log.size()), 32'd8);
    for (int k = 0; k < 8 && k < acc_log.size(); k++) begin
      check("grant_order", 32'(acc_log[k].id), 32'(k % 2));
      check("launch_spacing", 32'(acc_log[k].cyc - acc_log[0].cyc), 32'(3 * k));
    end
    repeat (6) @(negedge clk);

    // Reset during DEV: op dropped silently, next request runs normally.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'h2, 8'h00);
    wait_accept(1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("mid_rst_enable", 32'(bus.sram_enable), 32'd0);
    check("mid_rst_ready0", 32'(bus.req0_ready), 32'd0);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_rdata", 32'(bus.rsp_rdata), 32'd0);
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b1, 4'h5, 8'h00, 8'hA3, 1'b1, acc);
    repeat (5) @(negedge clk);

`ifdef SRAM_SYNC_CHECK_EN
    // Desync in SENSE: sticky error, response suppressed, 3 blocked cycles, then normal launch.
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 4'h3, 8'h00);
    wait_accept(1'b0, acc);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 4'h0, 8'h00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    force_nrdy = 1'b1;
    @(posedge clk); #1;
    force_nrdy = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 4'h5, 8'h00);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("sync_err_set", 32'(bus.sync_err), 32'd1);
      check("sync_hold_ready", 32'(bus.req1_ready), 32'd0);
      check("sync_hold_enable", 32'(bus.sram_enable), 32'd0);
    end
    @(negedge clk);
    check("sync_resume_ready", 32'(bus.req1_ready), 32'd1);
    if (bus.req1_ready) accepted(1'b1, cyc, 1'b1, 8'hA3);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 4'h0, 8'h00);
    repeat (6) @(negedge clk);
    check("sync_err_sticky", 32'(bus.sync_err), 32'd1);
`else
    check("sync_err_tied", 32'(bus.sync_err), 32'd0);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
